// File: rtl/miss_recovery_controller_pkg.sv
// Shared types for the branch-miss recovery controller.
//   BasicTypes    : machine PC width and PC type.
//   RecoveryTypes : recovery FSM state encoding and the one-deep BTB update entry.
// No ports; packages only.

package BasicTypes;
    localparam int ADDR_WIDTH = 32;
    typedef logic [ADDR_WIDTH-1:0] PC;
endpackage

package RecoveryTypes;
    import BasicTypes::*;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } RecoveryState;

    typedef struct packed {
        PC    pc;
        PC    target;
        logic taken;
    } BtbUpdate;
endpackage

// File: rtl/miss_recovery_controller_sat_counter.sv
// sat_counter: up-counter that sticks at all ones instead of wrapping.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-low reset, clears count
//   inc   in   count one event this cycle
//   count out  registered count value (WIDTH bits)

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/miss_recovery_controller.sv
// miss_recovery_controller: sequences pipeline recovery after a branch miss
// flagged at the confirmed stage. A qualified miss flushes every stage for
// FLUSH_CYCLES cycles, then a fetch redirect to the corrected PC is offered
// on a valid/ready handshake. Independently, a one-deep BTB update register
// captures the resolved branch, and saturating counters track misses and
// BTB updates lost to overwrite.
//
// Handshakes (redirect and BTB update): the producer raises valid with stable
// payload and holds both until a cycle in which valid && ready; the transfer
// happens at that edge. Ready may depend on nothing from this block.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   confirmedValid, isMiss        miss qualifier from the confirmed stage
//   irregPc, confirmedPc          corrected next PC, PC of the branch
//   isBranchTaken                 resolved direction
//   flush[NUM_STAGES]             per-stage flush (bit0 = fetch)
//   busy                          recovery in progress
//   redirectValid/Pc/Ready        fetch redirect handshake
//   btbUpdValid/Pc/Target/Taken/Ready  BTB update handshake
//   missCount, btbDropCount       saturating statistics

module miss_recovery_controller
    import RecoveryTypes::*;
#(
    parameter int ADDR_WIDTH   = BasicTypes::ADDR_WIDTH,
    parameter int NUM_STAGES   = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  confirmedValid,
    input  logic                  isMiss,
    input  logic [ADDR_WIDTH-1:0] irregPc,
    input  logic [ADDR_WIDTH-1:0] confirmedPc,
    input  logic                  isBranchTaken,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  busy,
    output logic                  redirectValid,
    output logic [ADDR_WIDTH-1:0] redirectPc,
    input  logic                  redirectReady,
    output logic                  btbUpdValid,
    output logic [ADDR_WIDTH-1:0] btbUpdPc,
    output logic [ADDR_WIDTH-1:0] btbUpdTarget,
    output logic                  btbUpdTaken,
    input  logic                  btbUpdReady,
    output logic [CNT_WIDTH-1:0]  missCount,
    output logic [CNT_WIDTH-1:0]  btbDropCount
);

    // Down-counter only needs to hold FLUSH_CYCLES-1.
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    RecoveryState          r_state;
    logic [FC_W-1:0]       r_flush_cnt;
    logic [ADDR_WIDTH-1:0] r_target_pc;
    BtbUpdate              r_btb;
    logic                  r_btb_valid;

    logic w_accept;
    logic w_btb_drop;

    // Misses are only meaningful from IDLE; anything later is wrong-path.
    assign w_accept   = (r_state == IDLE) && confirmedValid && isMiss;
    // A pending entry that cannot transfer this cycle is lost to the new one.
    assign w_btb_drop = w_accept && r_btb_valid && !btbUpdReady;

    // Recovery FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_flush_cnt   <= '0;
            r_target_pc   <= '0;
            flush         <= '0;
            busy          <= 1'b0;
            redirectValid <= 1'b0;
            redirectPc    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state     <= FLUSH;
                        r_target_pc <= irregPc;
                        r_flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
                        flush       <= '1;
                        busy        <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        r_state       <= REDIRECT;
                        flush         <= '0;
                        redirectValid <= 1'b1;
                        redirectPc    <= r_target_pc;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FC_W'(1);
                    end
                end
                REDIRECT: begin
                    if (redirectValid && redirectReady) begin
                        r_state       <= IDLE;
                        redirectValid <= 1'b0;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    flush         <= '0;
                    busy          <= 1'b0;
                    redirectValid <= 1'b0;
                end
            endcase
        end
    end

    // One-deep BTB update register. A load in the same cycle as a transfer
    // simply replaces the departing entry, so valid stays high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_btb       <= '0;
            r_btb_valid <= 1'b0;
        end else if (w_accept) begin
            r_btb.pc     <= confirmedPc;
            r_btb.target <= irregPc;
            r_btb.taken  <= isBranchTaken;
            r_btb_valid  <= 1'b1;
        end else if (r_btb_valid && btbUpdReady) begin
            r_btb_valid <= 1'b0;
        end
    end

    assign btbUpdValid  = r_btb_valid;
    assign btbUpdPc     = r_btb.pc;
    assign btbUpdTarget = r_btb.target;
    assign btbUpdTaken  = r_btb.taken;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_accept),
        .count (missCount)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_btb_drop),
        .count (btbDropCount)
    );

endmodule

// File: tb/tb_miss_recovery_controller.sv
// Directed bench for miss_recovery_controller. Two instances share every
// input: dut (32-bit counters) and dut_s (2-bit counters, for saturation).
// Inputs change #1 after a rising edge; outputs are sampled there too, so a
// sample after tick() reflects the edge just taken.

module tb_miss_recovery_controller;

    localparam int AW = 32;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          confirmedValid;
    logic          isMiss;
    logic [AW-1:0] irregPc;
    logic [AW-1:0] confirmedPc;
    logic          isBranchTaken;
    logic          redirectReady;
    logic          btbUpdReady;

    logic [NS-1:0] flush;
    logic          busy;
    logic          redirectValid;
    logic [AW-1:0] redirectPc;
    logic          btbUpdValid;
    logic [AW-1:0] btbUpdPc;
    logic [AW-1:0] btbUpdTarget;
    logic          btbUpdTaken;
    logic [31:0]   missCount;
    logic [31:0]   btbDropCount;

    logic [NS-1:0] s_flush;
    logic          s_busy;
    logic          s_redirectValid;
    logic [AW-1:0] s_redirectPc;
    logic          s_btbUpdValid;
    logic [AW-1:0] s_btbUpdPc;
    logic [AW-1:0] s_btbUpdTarget;
    logic          s_btbUpdTaken;
    logic [1:0]    s_missCount;
    logic [1:0]    s_btbDropCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    miss_recovery_controller #(
        .ADDR_WIDTH(AW), .NUM_STAGES(NS), .FLUSH_CYCLES(2), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst),
        .confirmedValid(confirmedValid), .isMiss(isMiss),
        .irregPc(irregPc), .confirmedPc(confirmedPc), .isBranchTaken(isBranchTaken),
        .flush(flush), .busy(busy),
        .redirectValid(redirectValid), .redirectPc(redirectPc), .redirectReady(redirectReady),
        .btbUpdValid(btbUpdValid), .btbUpdPc(btbUpdPc), .btbUpdTarget(btbUpdTarget),
        .btbUpdTaken(btbUpdTaken), .btbUpdReady(btbUpdReady),
        .missCount(missCount), .btbDropCount(btbDropCount)
    );

    miss_recovery_controller #(
        .ADDR_WIDTH(AW), .NUM_STAGES(NS), .FLUSH_CYCLES(2), .CNT_WIDTH(2)
    ) dut_s (
        .clk(clk), .rst(rst),
        .confirmedValid(confirmedValid), .isMiss(isMiss),
        .irregPc(irregPc), .confirmedPc(confirmedPc), .isBranchTaken(isBranchTaken),
        .flush(s_flush), .busy(s_busy),
        .redirectValid(s_redirectValid), .redirectPc(s_redirectPc), .redirectReady(redirectReady),
        .btbUpdValid(s_btbUpdValid), .btbUpdPc(s_btbUpdPc), .btbUpdTarget(s_btbUpdTarget),
        .btbUpdTaken(s_btbUpdTaken), .btbUpdReady(btbUpdReady),
        .missCount(s_missCount), .btbDropCount(s_btbDropCount)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic miss(input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input logic tk);
        confirmedValid = 1'b1;
        isMiss         = 1'b1;
        confirmedPc    = pc;
        irregPc        = tgt;
        isBranchTaken  = tk;
    endtask

    task automatic no_miss();
        confirmedValid = 1'b0;
        isMiss         = 1'b0;
    endtask

    initial begin
        rst = 1'b0; redirectReady = 1'b0; btbUpdReady = 1'b0;
        confirmedValid = 1'b1; isMiss = 1'b1;
        irregPc = 32'h55; confirmedPc = 32'h66; isBranchTaken = 1'b1;

        // 1. Reset with a miss presented: nothing may start.
        for (int i = 0; i < 3; i++) tick();
        check("rst_flush", 64'(flush), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_rv", 64'(redirectValid), 64'h0);
        check("rst_rpc", 64'(redirectPc), 64'h0);
        check("rst_bv", 64'(btbUpdValid), 64'h0);
        check("rst_bpc", 64'(btbUpdPc), 64'h0);
        check("rst_miss", 64'(missCount), 64'h0);
        check("rst_drop", 64'(btbDropCount), 64'h0);
        no_miss();
        rst = 1'b1;
        tick();

        // 2. Single miss, ready held high.
        redirectReady = 1'b1; btbUpdReady = 1'b1;
        miss(32'h10, 32'h100, 1'b1);
        tick();  // edge T
        no_miss();
        check("s_flush_t1", 64'(flush), 64'hF);
        check("s_busy_t1", 64'(busy), 64'h1);
        check("s_rv_t1", 64'(redirectValid), 64'h0);
        check("s_miss", 64'(missCount), 64'h1);
        check("s_bv", 64'(btbUpdValid), 64'h1);
        check("s_bpc", 64'(btbUpdPc), 64'h10);
        check("s_btgt", 64'(btbUpdTarget), 64'h100);
        check("s_btk", 64'(btbUpdTaken), 64'h1);
        tick();  // T+1
        check("s_flush_t2", 64'(flush), 64'hF);
        check("s_bv_gone", 64'(btbUpdValid), 64'h0);
        tick();  // T+2
        check("s_flush_t3", 64'(flush), 64'h0);
        check("s_rv_t3", 64'(redirectValid), 64'h1);
        check("s_rpc_t3", 64'(redirectPc), 64'h100);
        check("s_busy_t3", 64'(busy), 64'h1);
        tick();  // T+3
        check("s_rv_t4", 64'(redirectValid), 64'h0);
        check("s_busy_t4", 64'(busy), 64'h0);

        // 3. Redirect backpressure with wrong-path misses pulsed.
        redirectReady = 1'b0;
        miss(32'h20, 32'h180, 1'b0);
        tick();
        check("bp_miss", 64'(missCount), 64'h2);
        miss(32'h999, 32'h999, 1'b1);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            miss(32'h700 + 32'(i), 32'h900 + 32'(i), 1'b1);
            check("bp_rv", 64'(redirectValid), 64'h1);
            check("bp_rpc", 64'(redirectPc), 64'h180);
            check("bp_miss_hold", 64'(missCount), 64'h2);
            check("bp_bv", 64'(btbUpdValid), 64'h0);
            tick();
        end
        no_miss();
        redirectReady = 1'b1;
        tick();
        check("bp_rv_done", 64'(redirectValid), 64'h0);
        check("bp_busy_done", 64'(busy), 64'h0);
        check("bp_miss_end", 64'(missCount), 64'h2);

        // 4. BTB overwrite while not ready.
        btbUpdReady = 1'b0;
        miss(32'h40, 32'h200, 1'b0);
        tick();
        no_miss();
        check("ow_bpc1", 64'(btbUpdPc), 64'h40);
        tick(); tick(); tick();
        check("ow_idle", 64'(busy), 64'h0);
        check("ow_bv_held", 64'(btbUpdValid), 64'h1);
        check("ow_bpc_held", 64'(btbUpdPc), 64'h40);
        miss(32'h80, 32'h300, 1'b1);
        tick();
        no_miss();
        check("ow_bpc2", 64'(btbUpdPc), 64'h80);
        check("ow_btgt2", 64'(btbUpdTarget), 64'h300);
        check("ow_btk2", 64'(btbUpdTaken), 64'h1);
        check("ow_drop", 64'(btbDropCount), 64'h1);
        check("ow_miss", 64'(missCount), 64'h4);
        tick(); tick(); tick();
        btbUpdReady = 1'b1;
        tick();
        check("ow_xfer", 64'(btbUpdValid), 64'h0);
        tick();
        check("ow_one_xfer", 64'(btbUpdValid), 64'h0);

        // 4b. Accepted miss coinciding with a transfer: no drop.
        btbUpdReady = 1'b0;
        miss(32'hA0, 32'h400, 1'b0);
        tick();
        no_miss();
        tick(); tick(); tick();
        btbUpdReady = 1'b1;
        miss(32'hC0, 32'h500, 1'b1);
        tick();
        no_miss();
        check("sim_bv", 64'(btbUpdValid), 64'h1);
        check("sim_bpc", 64'(btbUpdPc), 64'hC0);
        check("sim_btgt", 64'(btbUpdTarget), 64'h500);
        check("sim_drop", 64'(btbDropCount), 64'h1);
        tick();
        check("sim_bv_gone", 64'(btbUpdValid), 64'h0);
        tick(); tick();

        // 5. isMiss without confirmedValid is ignored.
        isMiss = 1'b1; confirmedValid = 1'b0;
        tick(); tick();
        no_miss();
        check("q_flush", 64'(flush), 64'h0);
        check("q_busy", 64'(busy), 64'h0);
        check("q_miss", 64'(missCount), 64'h6);
        check("q_drop", 64'(btbDropCount), 64'h1);
        check("q_s_miss", 64'(s_missCount), 64'h3);

        // 6. Fresh reset, then 5 separated misses with BTB stalled:
        //    4 drops; the 2-bit instance saturates both counters at 3.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        btbUpdReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            miss(32'h1000 + 32'(i), 32'h2000 + 32'(i), 1'b0);
            tick();
            no_miss();
            tick(); tick(); tick();
        end
        check("sat_miss32", 64'(missCount), 64'h5);
        check("sat_drop32", 64'(btbDropCount), 64'h4);
        check("sat_miss2", 64'(s_missCount), 64'h3);
        check("sat_drop2", 64'(s_btbDropCount), 64'h3);
        check("sat_bpc", 64'(btbUpdPc), 64'h1004);

        //    Reset in the middle of FLUSH aborts recovery.
        btbUpdReady = 1'b1;
        miss(32'h3000, 32'h4000, 1'b1);
        tick();
        no_miss();
        check("ab_flush_on", 64'(flush), 64'hF);
        rst = 1'b0;
        tick();
        check("ab_flush", 64'(flush), 64'h0);
        check("ab_busy", 64'(busy), 64'h0);
        check("ab_miss", 64'(missCount), 64'h0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ab_no_rv", 64'(redirectValid), 64'h0);
            check("ab_no_flush", 64'(flush), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
